// File: rtl/test_axi_ram_pkg.sv
// Shared types and constants for the AXI4-to-test-RAM bridge.
package test_axi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WRESP,
        RREQ,
        RDATA
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat address/counter for one AXI burst: FIXED holds the address, every other
// burst type steps by one 8-byte beat.
module axi_burst_addr_gen
    import test_axi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  fixed_q, fixed_d;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        fixed_d = fixed_q;
        if (load_i) begin
            addr_d  = addr_i & ~ADDR_WIDTH'(BEAT_BYTES - 1);
            len_d   = len_i;
            cnt_d   = '0;
            fixed_d = (burst_i == BURST_FIXED);
        end else if (step_i) begin
            cnt_d = cnt_q + 8'd1;
            if (!fixed_q) begin
                addr_d = addr_q + ADDR_WIDTH'(BEAT_BYTES);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            fixed_q <= fixed_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/test_axi_ram_bridge_64.sv
// AXI4 slave front-end for the 64-bit byte-enable test RAM: serialises one read or
// write burst at a time into single-beat RAM accesses.
module test_axi_ram_bridge_64
    import test_axi_ram_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_BYTES  = 524288
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [1:0]            aw_burst_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [63:0]           w_data_i,
    input  logic [7:0]            w_strb_i,
    input  logic                  w_last_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [1:0]            ar_burst_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [63:0]           r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [7:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [63:0]           mem_wdata_o,
    input  logic [63:0]           mem_rdata_i
);
    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  wr_prio_q, wr_prio_d;   // 1: write wins the next AW/AR tie
    logic                  err_q, err_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  rd_fresh_q, rd_fresh_d; // RAM read data is live on mem_rdata_i

    logic                  wr_sel, rd_sel, gen_load, gen_step, gen_last, in_range;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [63:0]           rd_beat;
    logic                  unused_w_last;

    // Burst length alone terminates a write; WLAST carries no information here.
    assign unused_w_last = w_last_i;

    assign wr_sel   = !rst_i && aw_valid_i && (wr_prio_q || !ar_valid_i);
    assign rd_sel   = !rst_i && ar_valid_i && !wr_sel;
    assign gen_load = (state_q == IDLE) && (wr_sel || rd_sel);
    assign in_range = gen_addr < ADDR_WIDTH'(MEM_BYTES);
    assign rd_beat  = in_range ? mem_rdata_i : '0;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (gen_load),
        .addr_i  (wr_sel ? aw_addr_i : ar_addr_i),
        .len_i   (wr_sel ? aw_len_i : ar_len_i),
        .burst_i (wr_sel ? aw_burst_i : ar_burst_i),
        .step_i  (gen_step),
        .addr_o  (gen_addr),
        .last_o  (gen_last)
    );

    assign b_id_o     = id_q;
    assign r_id_o     = id_q;
    assign b_resp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign mem_addr_o = gen_addr;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        wr_prio_d   = wr_prio_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rd_fresh_d  = 1'b0;
        gen_step    = 1'b0;
        aw_ready_o  = 1'b0;
        ar_ready_o  = 1'b0;
        w_ready_o   = 1'b0;
        b_valid_o   = 1'b0;
        r_valid_o   = 1'b0;
        r_resp_o    = RESP_OKAY;
        r_last_o    = 1'b0;
        r_data_o    = rdata_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                aw_ready_o = wr_sel;
                ar_ready_o = rd_sel;
                if (wr_sel) begin
                    id_d      = aw_id_i;
                    wr_prio_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = WDATA;
                end else if (rd_sel) begin
                    id_d      = ar_id_i;
                    wr_prio_d = 1'b1;
                    state_d   = RREQ;
                end
            end
            WDATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    mem_req_o   = in_range;
                    mem_we_o    = in_range;
                    mem_be_o    = w_strb_i;
                    mem_wdata_o = w_data_i;
                    gen_step    = 1'b1;
                    if (!in_range) err_d = 1'b1;
                    if (gen_last) state_d = WRESP;
                end
            end
            WRESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RREQ: begin
                mem_req_o  = in_range;
                mem_be_o   = 8'hFF;
                rd_fresh_d = 1'b1;
                state_d    = RDATA;
            end
            RDATA: begin
                // First RDATA cycle forwards the RAM word and captures it so the beat stays stable.
                if (rd_fresh_q) begin
                    r_data_o = rd_beat;
                    rdata_d  = rd_beat;
                end
                r_valid_o = 1'b1;
                r_resp_o  = in_range ? RESP_OKAY : RESP_SLVERR;
                r_last_o  = gen_last;
                if (r_ready_i) begin
                    gen_step = 1'b1;
                    state_d  = gen_last ? IDLE : RREQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            wr_prio_q  <= 1'b1;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rd_fresh_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            wr_prio_q  <= wr_prio_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rd_fresh_q <= rd_fresh_d;
        end
    end

endmodule

// File: tb/tb_test_axi_ram_bridge_64.sv
// Randomised scoreboard bench for test_axi_ram_bridge_64 with a byte-level memory model
// and a behavioural RAM behind the bridge.
module tb_test_axi_ram_bridge_64;
    localparam int          ID_WIDTH   = 4;
    localparam int          ADDR_WIDTH = 64;
    localparam logic [63:0] MEM_BYTES  = 64'd524288;
    localparam int          TIMEOUT    = 3000;

    typedef struct { logic we; logic [63:0] addr; logic [7:0] be; logic [63:0] wdata; } mem_op_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [3:0] aw_id_i = '0, ar_id_i = '0, b_id_o, r_id_o;
    logic [63:0] aw_addr_i = '0, ar_addr_i = '0, mem_addr_o;
    logic [7:0] aw_len_i = '0, ar_len_i = '0, w_strb_i = '0, mem_be_o;
    logic [1:0] aw_burst_i = '0, ar_burst_i = '0, b_resp_o, r_resp_o;
    logic aw_valid_i = 1'b0, ar_valid_i = 1'b0, w_valid_i = 1'b0, w_last_i = 1'b0;
    logic b_ready_i = 1'b1, r_ready_i = 1'b1;
    logic aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o, mem_req_o, mem_we_o;
    logic [63:0] w_data_i = '0, r_data_o, mem_wdata_o, mem_rdata_i = '0;

    int checks = 0, failures = 0, r_mode = 0;
    mem_op_t exp_mem[$];
    b_exp_t  exp_b[$];
    r_exp_t  exp_r[$];
    logic [7:0]  ref_bytes [longint unsigned];
    logic [63:0] ram [65536];
    logic [63:0] ram_tmp;
    logic [63:0] wdata_a [256];
    logic [7:0]  wstrb_a [256];
    bit model_wr_prio = 1'b1;
    time aw_hs_t, ar_hs_t;

    always #5 clk_i = ~clk_i;

    test_axi_ram_bridge_64 #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(524288)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_burst_i(aw_burst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_valid_i(w_valid_i),
        .w_ready_o(w_ready_o),
        .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_burst_i(ar_burst_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // RAM behind the bridge: byte-enable writes, read data one cycle after the request.
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                ram_tmp = ram[mem_addr_o[18:3]];
                for (int b = 0; b < 8; b++)
                    if (mem_be_o[b]) ram_tmp[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                ram[mem_addr_o[18:3]] <= ram_tmp;
            end else begin
                mem_rdata_i <= ram[mem_addr_o[18:3]];
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        case (r_mode)
            0:       r_ready_i = 1'b1;
            1:       r_ready_i = ~r_ready_i;
            default: r_ready_i = ($urandom_range(0, 2) != 0);
        endcase
        b_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event/timeout, expected none", name);
    endtask

    // Monitor: every DUT output event is compared against the head of its scoreboard queue.
    mem_op_t m_op;
    b_exp_t  m_b;
    r_exp_t  m_r;
    bit r_stall = 1'b0, b_stall = 1'b0;
    logic [71:0] r_prev;
    logic [6:0]  b_prev;
    always @(negedge clk_i) begin
        if (rst_i) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (mem_req_o) begin
                if (exp_mem.size() == 0) fail_now("mem_unexpected");
                else begin
                    m_op = exp_mem.pop_front();
                    check("mem_we", 128'(mem_we_o), 128'(m_op.we));
                    check("mem_addr", 128'(mem_addr_o), 128'(m_op.addr));
                    check("mem_be", 128'(mem_be_o), 128'(m_op.be));
                    if (m_op.we) check("mem_wdata", 128'(mem_wdata_o), 128'(m_op.wdata));
                end
            end
            if (r_stall) check("r_stable", 128'({r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o}), 128'(r_prev));
            if (b_stall) check("b_stable", 128'({b_valid_o, b_id_o, b_resp_o}), 128'(b_prev));
            if (r_valid_o && r_ready_i) begin
                if (exp_r.size() == 0) fail_now("r_unexpected");
                else begin
                    m_r = exp_r.pop_front();
                    check("r_id", 128'(r_id_o), 128'(m_r.id));
                    check("r_data", 128'(r_data_o), 128'(m_r.data));
                    check("r_resp", 128'(r_resp_o), 128'(m_r.resp));
                    check("r_last", 128'(r_last_o), 128'(m_r.last));
                end
            end
            if (b_valid_o && b_ready_i) begin
                if (exp_b.size() == 0) fail_now("b_unexpected");
                else begin
                    m_b = exp_b.pop_front();
                    check("b_id", 128'(b_id_o), 128'(m_b.id));
                    check("b_resp", 128'(b_resp_o), 128'(m_b.resp));
                end
            end
            r_stall = r_valid_o && !r_ready_i;
            r_prev  = {r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o};
            b_stall = b_valid_o && !b_ready_i;
            b_prev  = {b_valid_o, b_id_o, b_resp_o};
        end
    end

    // Reference model: 8-byte beats, FIXED repeats the aligned address, all other bursts increment.
    function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [1:0] burst, input int i);
        logic [63:0] a;
        a = base & ~64'h7;
        return (burst == 2'b00) ? a : a + 64'(i) * 64'd8;
    endfunction

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < 8; b++)
            if (ref_bytes.exists(a + 64'(b))) w[b*8 +: 8] = ref_bytes[a + 64'(b)];
        return w;
    endfunction

    task automatic predict_write_beat(input logic [63:0] a, input int i, inout bit err);
        if (a < MEM_BYTES) begin
            exp_mem.push_back('{we: 1'b1, addr: a, be: wstrb_a[i], wdata: wdata_a[i]});
            for (int b = 0; b < 8; b++)
                if (wstrb_a[i][b]) ref_bytes[a + 64'(b)] = wdata_a[i][b*8 +: 8];
        end else err = 1'b1;
    endtask

    task automatic predict_write(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst);
        bit err;
        err = 1'b0;
        for (int i = 0; i <= len; i++) predict_write_beat(beat_addr(addr, burst, i), i, err);
        exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        model_wr_prio = 1'b0;
    endtask

    task automatic predict_read(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst);
        logic [63:0] a;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, burst, i);
            if (a < MEM_BYTES) begin
                exp_mem.push_back('{we: 1'b0, addr: a, be: 8'hFF, wdata: 64'h0});
                exp_r.push_back('{id: id, data: ref_word(a), resp: 2'b00, last: (i == len)});
            end else begin
                exp_r.push_back('{id: id, data: 64'h0, resp: 2'b10, last: (i == len)});
            end
        end
        model_wr_prio = 1'b1;
    endtask

    task automatic wait_hs(input int ch);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < TIMEOUT) begin
            @(negedge clk_i);
            case (ch)
                0:       ok = aw_ready_o;
                1:       ok = w_ready_o;
                default: ok = ar_ready_o;
            endcase
            n++;
        end
        if (!ok) fail_now("handshake_timeout");
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst);
        aw_id_i = id; aw_addr_i = addr; aw_len_i = 8'(len); aw_burst_i = burst; aw_valid_i = 1'b1;
        wait_hs(0);
        aw_hs_t = $time;
        aw_valid_i = 1'b0;
    endtask

    task automatic drive_w(input int first, input int last, input int len);
        for (int i = first; i <= last; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            w_data_i = wdata_a[i]; w_strb_i = wstrb_a[i]; w_last_i = (i == len); w_valid_i = 1'b1;
            wait_hs(1);
        end
        w_valid_i = 1'b0;
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst);
        ar_id_i = id; ar_addr_i = addr; ar_len_i = 8'(len); ar_burst_i = burst; ar_valid_i = 1'b1;
        wait_hs(2);
        ar_hs_t = $time;
        ar_valid_i = 1'b0;
    endtask

    task automatic fill_beats(input int len, input logic [7:0] strb);
        for (int i = 0; i <= len; i++) begin
            wdata_a[i] = {$urandom, $urandom};
            wstrb_a[i] = (strb == 8'h00) ? 8'($urandom) : strb;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_b.size() + exp_r.size() + exp_mem.size()) != 0 && n < TIMEOUT) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= TIMEOUT) begin
            fail_now("drain_timeout");
            exp_b.delete(); exp_r.delete(); exp_mem.delete();
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst);
        predict_write(id, addr, len, burst);
        drive_aw(id, addr, len, burst);
        drive_w(0, len, len);
        wait_drain();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst);
        predict_read(id, addr, len, burst);
        drive_ar(id, addr, len, burst);
        wait_drain();
    endtask

    task automatic do_both(input logic [63:0] waddr, input logic [63:0] raddr, input int len);
        bit wfirst;
        wfirst = model_wr_prio;
        fill_beats(len, 8'h00);
        if (wfirst) begin
            predict_write(4'h5, waddr, len, 2'b01);
            predict_read(4'hA, raddr, len, 2'b01);
        end else begin
            predict_read(4'hA, raddr, len, 2'b01);
            predict_write(4'h5, waddr, len, 2'b01);
        end
        fork
            begin drive_aw(4'h5, waddr, len, 2'b01); drive_w(0, len, len); end
            begin drive_ar(4'hA, raddr, len, 2'b01); end
        join
        check("grant_write_first", 128'(aw_hs_t < ar_hs_t), 128'(wfirst));
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 128'({aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, mem_req_o,
                                    mem_we_o, mem_be_o, b_resp_o, r_resp_o, r_last_o, b_id_o, r_id_o}), 128'h0);
        check({tag, "_data"}, {mem_addr_o, r_data_o}, 128'h0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        logic [1:0]  bu;
        int          ln;
        bit          err;
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i); #1;

        wdata_a[0] = 64'h1122334455667788; wstrb_a[0] = 8'hFF;
        do_write(4'h3, 64'h40, 0, 2'b01);
        do_read(4'h7, 64'h40, 0, 2'b01);

        fill_beats(3, 8'hFF);
        do_write(4'h1, 64'h100, 3, 2'b01);
        fill_beats(3, 8'h0F);
        do_write(4'h2, 64'h100, 3, 2'b01);
        do_read(4'h4, 64'h100, 3, 2'b01);

        fill_beats(0, 8'hFF);
        do_write(4'h6, 64'h200, 0, 2'b00);
        r_mode = 1;
        do_read(4'h9, 64'h200, 2, 2'b00);
        r_mode = 0;

        do_both(64'h300, 64'h100, 1);
        do_both(64'h308, 64'h300, 1);
        fill_beats(0, 8'hFF);
        do_write(4'hC, 64'h400, 0, 2'b01);
        do_both(64'h408, 64'h400, 0);

        do_read(4'hB, MEM_BYTES, 0, 2'b01);
        fill_beats(0, 8'hFF);
        do_write(4'hD, MEM_BYTES, 0, 2'b01);
        fill_beats(3, 8'h00);
        do_write(4'hE, MEM_BYTES - 64'd16, 3, 2'b01);
        do_read(4'hF, MEM_BYTES - 64'd16, 3, 2'b10);

        // Reset while beat 2 of an 8-beat write is on the bus: only beats 0 and 1 reach the RAM.
        fill_beats(7, 8'hFF);
        err = 1'b0;
        for (int i = 0; i < 2; i++) predict_write_beat(beat_addr(64'h1000, 2'b01, i), i, err);
        drive_aw(4'h8, 64'h1000, 7, 2'b01);
        drive_w(0, 1, 7);
        w_data_i = wdata_a[2]; w_strb_i = wstrb_a[2]; w_valid_i = 1'b1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("midburst_reset");
        @(posedge clk_i); #1;
        w_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_wr_prio = 1'b1;
        repeat (10) @(posedge clk_i); #1;
        fill_beats(0, 8'hF0);
        do_write(4'h2, 64'h1000, 0, 2'b01);
        do_read(4'h3, 64'h1000, 3, 2'b01);

        for (int t = 0; t < 30; t++) begin
            r_mode = $urandom_range(0, 2);
            a  = ($urandom_range(0, 3) == 0) ? MEM_BYTES - 64'd32 + 64'($urandom_range(0, 63))
                                             : 64'($urandom_range(0, 524287));
            bu = 2'($urandom_range(0, 3));
            ln = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) begin
                fill_beats(ln, 8'h00);
                do_write(4'($urandom), a, ln, bu);
            end else begin
                do_read(4'($urandom), a, ln, bu);
            end
        end
        r_mode = 0;
        repeat (5) @(posedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
